// File: rtl/sdram_stream_reader_if.sv
// Bundles the command, stream and SDRAM channel signals of the stream reader.
// master = the reader itself; slave = the environment (controller, consumer, command source).
interface sdram_stream_reader_if #(
    parameter int ADDR_BITS = 24,
    parameter int LEN_BITS  = 16
);
    logic                 start;
    logic [ADDR_BITS-1:0] start_addr;
    logic [LEN_BITS-1:0]  length;
    logic                 busy;
    logic                 done;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [15:0]          rd_data;
    logic                 mem_req;
    logic                 mem_ack;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_address;
    logic [15:0]          mem_data_write;
    logic [15:0]          mem_data_read;

    modport master (
        input  start, start_addr, length, rd_ready, mem_ack, mem_data_read,
        output busy, done, rd_valid, rd_data, mem_req, mem_we, mem_address, mem_data_write
    );

    modport slave (
        output start, start_addr, length, rd_ready, mem_ack, mem_data_read,
        input  busy, done, rd_valid, rd_data, mem_req, mem_we, mem_address, mem_data_write
    );
endinterface

// File: rtl/sdram_stream_reader.sv
// Reads a run of consecutive SDRAM words over a req/ack toggle channel into a
// small first-word-fall-through FIFO drained through a valid/ready port.
module sdram_stream_reader #(
    parameter int ADDR_BITS = 24,
    parameter int LEN_BITS  = 16,
    parameter int DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_stream_reader_if.master bus
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_FINISH} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] mem_address_q, mem_address_d;
    logic [LEN_BITS-1:0]  remaining_q, remaining_d;
    logic                 mem_req_q, mem_req_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [15:0]          fifo_mem [DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_BITS:0]    count_q;

    logic                 synced;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic                 rd_valid;

    // Any ack that is still owed (stale after reset, or from an aborted
    // transfer) blocks issue, and only WAIT ever pushes, so such data is dropped.
    assign synced   = (mem_req_q == bus.mem_ack);
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && bus.rd_ready && !flush;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        mem_address_d = mem_address_q;
        remaining_d   = remaining_q;
        mem_req_d     = mem_req_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        push          = 1'b0;
        flush         = 1'b0;

        if (bus.start) begin
            flush       = 1'b1;
            addr_d      = bus.start_addr;
            remaining_d = bus.length;
            busy_d      = 1'b1;
            state_d     = (bus.length == '0) ? ST_FINISH : ST_ISSUE;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_ISSUE: begin
                    if (remaining_q != '0 && count_q < FULL_COUNT && synced) begin
                        mem_req_d     = ~mem_req_q;
                        mem_address_d = addr_q;
                        state_d       = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (synced) begin
                        push        = 1'b1;
                        addr_d      = addr_q + ADDR_BITS'(1);
                        remaining_d = remaining_q - LEN_BITS'(1);
                        state_d     = (remaining_q == LEN_BITS'(1)) ? ST_FINISH : ST_ISSUE;
                    end
                end
                ST_FINISH: begin
                    if (count_q == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            mem_address_q <= '0;
            remaining_q   <= '0;
            mem_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            mem_address_q <= mem_address_d;
            remaining_q   <= remaining_d;
            mem_req_q     <= mem_req_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Slot space was reserved at issue, so a push can never find the FIFO full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PTR_BITS + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PTR_BITS + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.mem_data_read;
        end
    end

    assign bus.rd_valid       = rd_valid;
    assign bus.rd_data        = rd_valid ? fifo_mem[rd_ptr_q] : 16'h0000;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_we         = 1'b0;
    assign bus.mem_data_write = 16'h0000;
endmodule

// File: doc/sdram_stream_reader.md
Name: sdram_stream_reader

Overview:
- Initiator (requester) for one SDRAM controller channel, driving the channel's req/ack toggle handshake from the master side.
- On a start command it reads a run of consecutive 16-bit words from SDRAM, one request at a time, into a small prefetch FIFO.
- A streaming consumer drains the FIFO through a valid/ready port. Typical users are mapper/PPU/APU fetch paths that need sequential ROM data.

Parameters:
- ADDR_BITS, 24, word-address width of the SDRAM channel.
- LEN_BITS, 16, width of the transfer length in words.
- DEPTH, 8, prefetch FIFO depth in words; power of two, minimum 2.

Ports:
- clk  in  1  system clock; SDRAM controller clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches start_addr/length and begins a transfer.
- start_addr  in  ADDR_BITS  first word address.
- length  in  LEN_BITS  number of words to read; 0 is legal.
- busy  out  1  high from accepted start until the last word is popped.
- done  out  1  one-cycle pulse after the last word is popped.
- rd_valid  out  1  FIFO head word is valid (first-word fall-through).
- rd_ready  in  1  consumer accepts the head word when rd_valid && rd_ready.
- rd_data  out  16  FIFO head word.
- mem_req  out  1  channel request toggle.
- mem_ack  in  1  channel acknowledge toggle.
- mem_we  out  1  constant 0; this block only reads.
- mem_address  out  ADDR_BITS  word address of the current request.
- mem_data_write  out  16  constant 0.
- mem_data_read  in  16  read data; valid in the cycle mem_ack first equals mem_req.

Behaviour:
- Handshake:
  - A request is outstanding while mem_req != mem_ack.
  - Issue = toggle mem_req and load mem_address on the same edge.
  - mem_address is held stable while the request is outstanding.
  - A new request is never issued while one is outstanding; at most one is in flight.
- Reset values:
  - mem_req=0, mem_address=0, busy=0, done=0, rd_valid=0, rd_data=0.
  - FIFO empty, state IDLE.
- Post-reset sync: no request is issued until mem_ack == mem_req is observed. This tolerates a stale ack from a request interrupted by reset; the stale completion is discarded, not pushed.
- States:
  - IDLE: on start, latch addr and remaining=length, set busy. Go to ISSUE, or to FINISH if length=0.
  - ISSUE: when remaining>0 and (fifo_count + 1) <= DEPTH, toggle mem_req, drive addr, go to WAIT. Otherwise hold.
  - WAIT: in the first cycle with mem_ack == mem_req:
    - Push mem_data_read into the FIFO on that edge.
    - addr <= addr+1, wrapping modulo 2^ADDR_BITS; remaining <= remaining-1.
    - Go to ISSUE, or to FINISH if remaining was 1.
  - FINISH: wait for FIFO empty. Then drop busy, pulse done for 1 cycle, go to IDLE.
- Timing:
  - Minimum 2 cycles between successive issues: issue edge, then ack cycle.
  - Read throughput = controller latency + 1 cycle per word.
- FIFO:
  - Slot space is reserved at issue, so a push never overflows.
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - A pop from a 1-entry FIFO in the same cycle as a push leaves rd_valid=1 with the new word.
- Start while busy (restart):
  - Flush the FIFO immediately and latch the new start_addr/length.
  - If a request is outstanding, its completion is discarded (not pushed) and counts as no word.
  - The new transfer's first issue happens only after that ack.
  - No done pulse is generated for the aborted transfer.
- Start and the final pop in the same cycle: the restart wins; no done pulse.
- rd_ready while rd_valid=0 is ignored.
- length=0: busy is high for exactly 1 cycle, then done pulses; zero memory requests are issued.

Test Plan:
- Basic read: preload SDRAM 0x100..0x103 = 0x1111,0x2222,0x3333,0x4444; start_addr=0x100, length=4, rd_ready=1.
  -> Exactly 4 mem_req toggles at addresses 0x100..0x103; rd_data sequence as preloaded; one done pulse; busy low afterwards.
- Backpressure: length=20, DEPTH=8, rd_ready=0 for 200 cycles, then 1.
  -> Exactly 8 requests issued, then mem_req stalls; FIFO holds words 0..7. After release, all 20 words arrive in order with no loss or duplication.
- Address wrap: start_addr=0xFFFFFE, length=4.
  -> Request addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- Zero length: start with length=0.
  -> busy high 1 cycle, done pulse next, mem_req unchanged, rd_valid never asserted.
- Restart mid-request: start length=10 at 0x200; pulse start at 0x300/length=2 while a request is outstanding.
  -> The outstanding read's data is not delivered; FIFO flushed; output is exactly the words at 0x300 and 0x301; a single done pulse.
- Reset mid-request: assert reset with a request outstanding, release, then start 0x400/length=1.
  -> No request issued until mem_ack == mem_req; the stale completion is not pushed; one word, from 0x400, delivered.
